hdlc_host_master: RTL and testbench
===================================

Name: hdlc_host_master

Overview:
- Bus initiator for the HDLC controller's 3-bit-address register interface. It drives Address, WriteEnable, ReadEnable and DataIn, and samples DataOut.
- TX: converts a host byte stream into writes to the TX buffer, starts transmission and polls for completion.
- RX: polls RX status, reads the frame length and frame bytes, and streams them out. Errored frames are reported and dropped.
- Sits between a host/testbench stream source/sink and the controller's register interface; connects net-for-net to it.

Parameters:
- POLL_INTERVAL, 16, idle cycles between RX status polls while in IDLE (range 2..255).
- FCS_EN, 1, value written to RX control bit 5 (FCS check enable) on every RX control write.
- MAX_TX_BYTES, 126, TX buffer capacity; enable is forced after this many bytes.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- Address  out  3  register address: 0=TX SC, 1=TX buff, 2=RX SC, 3=RX buff, 4=RX len.
- WriteEnable  out  1  one-cycle write strobe.
- ReadEnable  out  1  one-cycle read strobe.
- DataIn  out  8  write data to the responder.
- DataOut  in  8  read data; combinational from the responder, valid in the ReadEnable cycle.
- TxData  in  8  byte to send.
- TxValid  in  1  TxData valid.
- TxLast  in  1  last byte of frame, qualified by TxValid.
- TxReady  out  1  byte accepted when TxValid&TxReady.
- TxAbortReq  in  1  abort the current TX frame.
- TxDone  out  1  one-cycle pulse: frame transmitted.
- TxAborted  out  1  one-cycle pulse: transmission aborted.
- RxData  out  8  received byte.
- RxValid  out  1  RxData valid; held until RxReady.
- RxLast  out  1  final byte of frame, qualified by RxValid.
- RxReady  in  1  sink accepts byte.
- RxError  out  3  {overflow, aborted, frame error}; valid with RxErrValid.
- RxErrValid  out  1  one-cycle pulse: frame dropped.
- Busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset in any state aborts the operation and enters INIT the next cycle; no bus strobe is issued in the cycle following reset.
- Bus rules:
  - At most one of WriteEnable/ReadEnable is high in any cycle.
  - Address/DataIn are valid in the strobe cycle.
  - Every strobe is followed by at least one cycle with both strobes low.
  - Read data is captured at the clock edge ending the ReadEnable cycle.
- INIT: write addr 2, data = FCS_EN<<5. Then go to IDLE and load the poll timer with POLL_INTERVAL.
- IDLE:
  - The poll timer decrements each cycle.
  - If the timer is 0, go to RX_POLL (RX has priority).
  - Otherwise, if TxValid, go to TX_WRITE.
- TX_WRITE:
  - TxReady is high only in strobe-free cycles and when count < MAX_TX_BYTES.
  - Each accepted byte produces a write to addr 1 with DataIn=TxData in the next cycle; count increments.
  - After a byte with TxLast, or the MAX_TX_BYTES-th byte, go to TX_ENABLE.
  - A frame may stall indefinitely (TxValid low) in TX_WRITE; RX polling is suspended during this.
- TX_ENABLE: write addr 0, data 0x02. Then TX_SETTLE (2 idle cycles, covering registered status latency), then TX_POLL.
- TX_POLL:
  - Read addr 0 every other cycle.
  - DataOut[3]=1 → TxAborted pulse, go to IDLE.
  - Otherwise DataOut[0]=1 → TxDone pulse, go to IDLE.
  - Otherwise keep polling.
- TxAbortReq in TX_WRITE, TX_SETTLE or TX_POLL (sampled high):
  - Write addr 0, data 0x04 at the next legal strobe slot.
  - Pulse TxAborted, clear count, go to IDLE.
  - TxAbortReq in IDLE is ignored.
- RX_POLL: read addr 2. Status s = DataOut.
  - s[0]=0 → IDLE, timer reloaded.
  - s[0]=1 and any of s[4:2] set → RxErrValid pulse, RxError=s[4:2], go to RX_DROP.
  - Otherwise → RX_LEN.
- RX_LEN: read addr 4 into len.
  - len=0 → RX_DROP with RxErrValid pulse, RxError=3'b000.
  - Otherwise → RX_READ, remaining=len.
- RX_READ:
  - Issue a read of addr 3 only when the output register is empty, or is being emptied this cycle (RxValid&RxReady), and the gap rule is met.
  - Captured byte → RxData, RxValid=1, RxLast=(remaining==1); remaining decrements.
  - Exactly len reads of addr 3 per frame; a stalled sink never causes an extra or duplicate read.
  - After the last byte is accepted → RX_SETTLE.
- RX_DROP: write addr 2, data 0x02 | FCS_EN<<5. Then → RX_SETTLE.
- RX_SETTLE: 2 idle cycles, then → IDLE, timer reloaded.

Test Plan:
- Rst high 3 cycles, then low → all outputs 0. First strobe is a write to addr 2, data 0x20. Busy falls after it.
- TX frame A1,B2,C3 (TxLast on C3) → writes to addr 1 with data A1, B2, C3, each separated by ≥1 idle cycle. Then write to addr 0 with data 0x02. Responder returns 0x00 for two polls, then 0x01 → exactly one TxDone pulse; no TxAborted.
- RX: addr 2 read returns 0x21, addr 4 returns 0x04, bytes 11,22,33,44 → RxData sequence 11,22,33,44 with RxLast only on 44. Holding RxReady low 5 cycles during byte 22 → exactly 4 addr-3 reads total.
- RX error: addr 2 read returns 0x09 → RxErrValid pulse with RxError=3'b010, then write to addr 2 with data 0x22, no addr-3 reads. With FCS_EN=0 the data is 0x02.
- TxAbortReq during TX_POLL → write to addr 0 with data 0x04, one TxAborted pulse, IDLE. A subsequent frame starts from count 0.
- Stream 130 bytes without TxLast → after the 126th write to addr 1, TxReady stays low, write to addr 0 with data 0x02 follows, and the remaining bytes are only accepted after TxDone.

Source files
------------

// File: rtl/hdlc_host_master.sv
// Register-bus initiator for the HDLC controller: turns a host byte stream into
// TX buffer writes and drains received frames from the RX buffer into a stream.
module hdlc_host_master #(
    parameter int POLL_INTERVAL = 16,
    parameter int FCS_EN        = 1,
    parameter int MAX_TX_BYTES  = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    input  logic       TxLast,
    output logic       TxReady,
    input  logic       TxAbortReq,
    output logic       TxDone,
    output logic       TxAborted,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxLast,
    input  logic       RxReady,
    output logic [2:0] RxError,
    output logic       RxErrValid,
    output logic       Busy
);

    localparam logic [2:0] A_TX_SC  = 3'd0;
    localparam logic [2:0] A_TX_BUF = 3'd1;
    localparam logic [2:0] A_RX_SC  = 3'd2;
    localparam logic [2:0] A_RX_BUF = 3'd3;
    localparam logic [2:0] A_RX_LEN = 3'd4;

    localparam logic [7:0] RX_CTRL     = (FCS_EN != 0) ? 8'h20 : 8'h00;
    localparam logic [7:0] RX_DROP_CMD = RX_CTRL | 8'h02;
    localparam logic [7:0] POLL_LOAD   = 8'(POLL_INTERVAL);
    localparam logic [7:0] TX_MAX      = 8'(MAX_TX_BYTES);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_TX_WRITE, S_TX_ENABLE, S_TX_SETTLE, S_TX_POLL,
        S_TX_ABORT, S_RX_POLL, S_RX_LEN, S_RX_READ, S_RX_DROP, S_RX_SETTLE
    } state_t;

    state_t     state;
    logic [7:0] poll_tmr;
    logic [7:0] tx_cnt;
    logic [7:0] rx_left;
    logic [1:0] settle;

    logic bus_busy;
    logic tx_accept;
    logic rx_pop;

    // A strobe this cycle forbids one in the next: that is the mandatory gap.
    assign bus_busy  = WriteEnable | ReadEnable;
    assign tx_accept = TxValid & TxReady;
    assign rx_pop    = RxValid & RxReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_INIT;
            poll_tmr    <= 8'd0;
            tx_cnt      <= 8'd0;
            rx_left     <= 8'd0;
            settle      <= 2'd0;
            Address     <= 3'd0;
            WriteEnable <= 1'b0;
            ReadEnable  <= 1'b0;
            DataIn      <= 8'd0;
            TxReady     <= 1'b0;
            TxDone      <= 1'b0;
            TxAborted   <= 1'b0;
            RxData      <= 8'd0;
            RxValid     <= 1'b0;
            RxLast      <= 1'b0;
            RxError     <= 3'd0;
            RxErrValid  <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            ReadEnable  <= 1'b0;
            TxReady     <= 1'b0;
            TxDone      <= 1'b0;
            TxAborted   <= 1'b0;
            RxErrValid  <= 1'b0;
            if (rx_pop) begin
                RxValid <= 1'b0;
                RxLast  <= 1'b0;
            end

            case (state)
                S_INIT: begin
                    WriteEnable <= 1'b1;
                    Address     <= A_RX_SC;
                    DataIn      <= RX_CTRL;
                    poll_tmr    <= POLL_LOAD;
                    Busy        <= 1'b0;
                    state       <= S_IDLE;
                end

                S_IDLE: begin
                    if (poll_tmr == 8'd0) begin
                        Busy  <= 1'b1;
                        state <= S_RX_POLL;
                    end else begin
                        poll_tmr <= poll_tmr - 8'd1;
                        if (TxValid) begin
                            TxReady <= 1'b1;
                            Busy    <= 1'b1;
                            state   <= S_TX_WRITE;
                        end
                    end
                end

                S_TX_WRITE: begin
                    if (TxAbortReq) begin
                        state <= S_TX_ABORT;
                    end else if (tx_accept) begin
                        WriteEnable <= 1'b1;
                        Address     <= A_TX_BUF;
                        DataIn      <= TxData;
                        tx_cnt      <= tx_cnt + 8'd1;
                        if (TxLast || (tx_cnt + 8'd1 == TX_MAX))
                            state <= S_TX_ENABLE;
                    end else begin
                        TxReady <= (tx_cnt < TX_MAX);
                    end
                end

                S_TX_ENABLE: begin
                    if (!bus_busy) begin
                        WriteEnable <= 1'b1;
                        Address     <= A_TX_SC;
                        DataIn      <= 8'h02;
                        tx_cnt      <= 8'd0;
                        settle      <= 2'd2;
                        state       <= S_TX_SETTLE;
                    end
                end

                // Give the responder's registered status time to reflect the enable.
                S_TX_SETTLE: begin
                    if (TxAbortReq)
                        state <= S_TX_ABORT;
                    else if (settle == 2'd1)
                        state <= S_TX_POLL;
                    else
                        settle <= settle - 2'd1;
                end

                S_TX_POLL: begin
                    if (ReadEnable) begin
                        if (DataOut[3]) begin
                            TxAborted <= 1'b1;
                            Busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else if (DataOut[0]) begin
                            TxDone <= 1'b1;
                            Busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else if (TxAbortReq) begin
                            state <= S_TX_ABORT;
                        end
                    end else if (TxAbortReq) begin
                        state <= S_TX_ABORT;
                    end else if (!bus_busy) begin
                        ReadEnable <= 1'b1;
                        Address    <= A_TX_SC;
                    end
                end

                S_TX_ABORT: begin
                    if (!bus_busy) begin
                        WriteEnable <= 1'b1;
                        Address     <= A_TX_SC;
                        DataIn      <= 8'h04;
                        TxAborted   <= 1'b1;
                        tx_cnt      <= 8'd0;
                        Busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                S_RX_POLL: begin
                    if (ReadEnable) begin
                        if (!DataOut[0]) begin
                            poll_tmr <= POLL_LOAD;
                            Busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else if (|DataOut[4:2]) begin
                            RxErrValid <= 1'b1;
                            RxError    <= DataOut[4:2];
                            state      <= S_RX_DROP;
                        end else begin
                            state <= S_RX_LEN;
                        end
                    end else if (!bus_busy) begin
                        ReadEnable <= 1'b1;
                        Address    <= A_RX_SC;
                    end
                end

                S_RX_LEN: begin
                    if (ReadEnable) begin
                        if (DataOut == 8'd0) begin
                            RxErrValid <= 1'b1;
                            RxError    <= 3'b000;
                            state      <= S_RX_DROP;
                        end else begin
                            rx_left <= DataOut;
                            state   <= S_RX_READ;
                        end
                    end else if (!bus_busy) begin
                        ReadEnable <= 1'b1;
                        Address    <= A_RX_LEN;
                    end
                end

                // At most one read outstanding, and only into a free output slot,
                // so rx_left is also the number of reads still to issue.
                S_RX_READ: begin
                    if (ReadEnable) begin
                        RxData  <= DataOut;
                        RxValid <= 1'b1;
                        RxLast  <= (rx_left == 8'd1);
                        rx_left <= rx_left - 8'd1;
                    end else if (rx_left == 8'd0) begin
                        if (rx_pop) begin
                            settle <= 2'd2;
                            state  <= S_RX_SETTLE;
                        end
                    end else if (!bus_busy && (!RxValid || rx_pop)) begin
                        ReadEnable <= 1'b1;
                        Address    <= A_RX_BUF;
                    end
                end

                S_RX_DROP: begin
                    if (!bus_busy) begin
                        WriteEnable <= 1'b1;
                        Address     <= A_RX_SC;
                        DataIn      <= RX_DROP_CMD;
                        settle      <= 2'd2;
                        state       <= S_RX_SETTLE;
                    end
                end

                S_RX_SETTLE: begin
                    if (settle == 2'd1) begin
                        poll_tmr <= POLL_LOAD;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        settle <= settle - 2'd1;
                    end
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_host_master.sv
// Directed bench for hdlc_host_master: a register-bus responder model, stream
// drivers and table-driven expectations for TX, RX, error, abort and limit cases.
module tb_hdlc_host_master;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] Address;
    logic       WriteEnable, ReadEnable;
    logic [7:0] DataIn, DataOut;
    logic [7:0] TxData = 8'h00;
    logic       TxValid = 1'b0, TxLast = 1'b0, TxAbortReq = 1'b0;
    logic       TxReady, TxDone, TxAborted;
    logic [7:0] RxData;
    logic       RxValid, RxLast, RxErrValid, Busy;
    logic       RxReady = 1'b1;
    logic [2:0] RxError;

    // second instance with FCS check disabled and a responder that always reports an error
    logic [2:0] d0_Address;
    logic       d0_WriteEnable, d0_ReadEnable, d0_TxReady, d0_TxDone, d0_TxAborted;
    logic [7:0] d0_DataIn, d0_RxData;
    logic       d0_RxValid, d0_RxLast, d0_RxErrValid, d0_Busy;
    logic [2:0] d0_RxError;

    always #5 Clk = ~Clk;

    hdlc_host_master u_dut (
        .Clk(Clk), .Rst(Rst), .Address(Address), .WriteEnable(WriteEnable),
        .ReadEnable(ReadEnable), .DataIn(DataIn), .DataOut(DataOut),
        .TxData(TxData), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
        .TxAbortReq(TxAbortReq), .TxDone(TxDone), .TxAborted(TxAborted),
        .RxData(RxData), .RxValid(RxValid), .RxLast(RxLast), .RxReady(RxReady),
        .RxError(RxError), .RxErrValid(RxErrValid), .Busy(Busy)
    );

    hdlc_host_master #(.FCS_EN(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .Address(d0_Address), .WriteEnable(d0_WriteEnable),
        .ReadEnable(d0_ReadEnable), .DataIn(d0_DataIn), .DataOut(8'h09),
        .TxData(8'h00), .TxValid(1'b0), .TxLast(1'b0), .TxReady(d0_TxReady),
        .TxAbortReq(1'b0), .TxDone(d0_TxDone), .TxAborted(d0_TxAborted),
        .RxData(d0_RxData), .RxValid(d0_RxValid), .RxLast(d0_RxLast), .RxReady(1'b1),
        .RxError(d0_RxError), .RxErrValid(d0_RxErrValid), .Busy(d0_Busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    int         tx_polls = 0;
    int         tx_done_at = 1 << 20;
    logic [7:0] tx_done_val = 8'h01;
    int         rx_req = 0, rx_served = 0, rx3_reads = 0;
    logic [7:0] rx_stat_val = 8'h00, rx_len_val = 8'h00;
    logic [7:0] rx_mem [0:3];
    logic [1:0] rx_idx;

    assign rx_idx = rx3_reads[1:0];

    always_comb begin
        DataOut = 8'h00;
        if (ReadEnable) begin
            case (Address)
                3'd0: DataOut = (tx_polls >= tx_done_at) ? tx_done_val : 8'h00;
                3'd2: DataOut = (rx_served < rx_req) ? rx_stat_val : 8'h00;
                3'd3: DataOut = rx_mem[rx_idx];
                3'd4: DataOut = rx_len_val;
                default: DataOut = 8'h00;
            endcase
        end
    end

    always @(posedge Clk) begin
        if (!Rst) begin
            if (ReadEnable && Address == 3'd0) tx_polls <= tx_polls + 1;
            if (ReadEnable && Address == 3'd2 && rx_served < rx_req) rx_served <= rx_served + 1;
            if (ReadEnable && Address == 3'd3) rx3_reads <= rx3_reads + 1;
        end
    end

    // ---------------- monitors ----------------
    logic [10:0] wlog[$];
    logic [10:0] w0log[$];
    logic [7:0]  rxq_d[$];
    logic        rxq_l[$];
    int          txdone_cnt = 0, txab_cnt = 0, rxerr_cnt = 0, bus_viol = 0;
    logic [2:0]  rxerr_last = 3'd7, d0_err_last = 3'd7;
    logic        prev_strobe = 1'b0;

    always @(negedge Clk) begin
        if (WriteEnable) wlog.push_back({Address, DataIn});
        if (d0_WriteEnable) w0log.push_back({d0_Address, d0_DataIn});
        if (TxDone) txdone_cnt <= txdone_cnt + 1;
        if (TxAborted) txab_cnt <= txab_cnt + 1;
        if (RxErrValid) begin
            rxerr_cnt  <= rxerr_cnt + 1;
            rxerr_last <= RxError;
        end
        if (d0_RxErrValid) d0_err_last <= d0_RxError;
        if (RxValid && RxReady) begin
            rxq_d.push_back(RxData);
            rxq_l.push_back(RxLast);
        end
        if (WriteEnable && ReadEnable) bus_viol <= bus_viol + 1;
        if ((WriteEnable || ReadEnable) && prev_strobe) bus_viol <= bus_viol + 1;
        prev_strobe <= WriteEnable || ReadEnable;
    end

    function automatic logic [10:0] wl(input int i);
        return (i < wlog.size()) ? wlog[i] : 11'h7FF;
    endfunction

    function automatic logic [10:0] w0l(input int i);
        return (i < w0log.size()) ? w0log[i] : 11'h7FF;
    endfunction

    logic [30:0] outs;
    assign outs = {Address, WriteEnable, ReadEnable, DataIn, TxReady, TxDone, TxAborted,
                   RxData, RxValid, RxLast, RxError, RxErrValid, Busy};

    task automatic send_byte(input logic [7:0] d, input logic l, output logic ok);
        TxData = d; TxValid = 1'b1; TxLast = l; ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk);
            if (TxReady) ok = 1'b1;
            @(posedge Clk); #1;
        end
        TxValid = 1'b0; TxLast = 1'b0;
    endtask

    typedef struct {
        logic       send;
        logic [7:0] din;
        logic       last;
        logic [2:0] exp_addr;
        logic [7:0] exp_data;
    } txvec_t;

    typedef struct {
        logic [7:0] mem;
        logic [7:0] exp_d;
        logic       exp_l;
    } rxvec_t;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        txvec_t tx_tab[4];
        rxvec_t rx_tab[4];
        logic   ok;
        int     mark, base_done, base_ab, tp, r3, rqmark, ebase, pre_done, acc_fail;

        tx_tab[0] = '{1'b1, 8'hA1, 1'b0, 3'd1, 8'hA1};
        tx_tab[1] = '{1'b1, 8'hB2, 1'b0, 3'd1, 8'hB2};
        tx_tab[2] = '{1'b1, 8'hC3, 1'b1, 3'd1, 8'hC3};
        tx_tab[3] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'h02};
        rx_tab[0] = '{8'h11, 8'h11, 1'b0};
        rx_tab[1] = '{8'h22, 8'h22, 1'b0};
        rx_tab[2] = '{8'h33, 8'h33, 1'b0};
        rx_tab[3] = '{8'h44, 8'h44, 1'b1};

        // reset
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_outputs", 32'(outs), 32'd0);
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        chk("post_reset_quiet", 32'(outs), 32'd0);
        for (int i = 0; i < 20 && wlog.size() == 0; i++) @(negedge Clk);
        chk("init_write", 32'(wl(0)), {21'd0, 3'd2, 8'h20});
        repeat (2) @(negedge Clk);
        chk("busy_after_init", 32'(Busy), 32'd0);

        // TX frame from table
        mark = wlog.size(); base_done = txdone_cnt; base_ab = txab_cnt;
        tp = tx_polls; tx_done_at = tx_polls + 2; tx_done_val = 8'h01;
        for (int i = 0; i < 4; i++)
            if (tx_tab[i].send) begin
                send_byte(tx_tab[i].din, tx_tab[i].last, ok);
                chk("tx_accept", 32'(ok), 32'd1);
            end
        for (int i = 0; i < 200 && txdone_cnt == base_done; i++) @(negedge Clk);
        repeat (10) @(negedge Clk);
        for (int i = 0; i < 4; i++)
            chk("tx_write", 32'(wl(mark + i)), {21'd0, tx_tab[i].exp_addr, tx_tab[i].exp_data});
        chk("tx_done_pulses", 32'(txdone_cnt - base_done), 32'd1);
        chk("tx_no_abort", 32'(txab_cnt - base_ab), 32'd0);
        chk("tx_poll_count", 32'(tx_polls - tp), 32'd3);

        // RX frame with a stalled sink on the second byte
        for (int i = 0; i < 4; i++) rx_mem[i] = rx_tab[i].mem;
        rx_len_val = 8'h04; rx_stat_val = 8'h21;
        rqmark = rxq_d.size(); r3 = rx3_reads;
        rx_req = rx_req + 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge Clk); #1;
            if (RxValid && RxData == 8'h22) break;
        end
        RxReady = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("rx_hold", {23'd0, RxValid, RxData}, {23'd0, 1'b1, 8'h22});
        chk("rx_stall_reads", 32'(rx3_reads - r3), 32'd2);
        RxReady = 1'b1;
        for (int i = 0; i < 300 && rxq_d.size() < rqmark + 4; i++) @(negedge Clk);
        repeat (30) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            chk("rx_data", 32'((rqmark + i < rxq_d.size()) ? rxq_d[rqmark + i] : 8'hXX),
                32'(rx_tab[i].exp_d));
            chk("rx_last", 32'((rqmark + i < rxq_l.size()) ? rxq_l[rqmark + i] : 1'bx),
                32'(rx_tab[i].exp_l));
        end
        chk("rx_addr3_reads", 32'(rx3_reads - r3), 32'd4);
        chk("rx_byte_count", 32'(rxq_d.size() - rqmark), 32'd4);

        // RX errored frame
        mark = wlog.size(); ebase = rxerr_cnt; r3 = rx3_reads;
        rx_stat_val = 8'h09;
        rx_req = rx_req + 1;
        for (int i = 0; i < 200 && rxerr_cnt == ebase; i++) @(negedge Clk);
        repeat (10) @(negedge Clk);
        chk("rx_err_pulses", 32'(rxerr_cnt - ebase), 32'd1);
        chk("rx_err_code", 32'(rxerr_last), 32'd2);
        chk("rx_drop_write", 32'(wl(mark)), {21'd0, 3'd2, 8'h22});
        chk("rx_err_no_reads", 32'(rx3_reads - r3), 32'd0);

        // TX abort while polling
        mark = wlog.size(); base_done = txdone_cnt; base_ab = txab_cnt;
        tp = tx_polls; tx_done_at = tx_polls + 1000;
        send_byte(8'h55, 1'b0, ok);
        chk("abort_accept0", 32'(ok), 32'd1);
        send_byte(8'h66, 1'b1, ok);
        chk("abort_accept1", 32'(ok), 32'd1);
        for (int i = 0; i < 200 && tx_polls == tp; i++) begin
            @(posedge Clk); #1;
        end
        TxAbortReq = 1'b1;
        @(posedge Clk); #1 TxAbortReq = 1'b0;
        for (int i = 0; i < 100 && txab_cnt == base_ab; i++) @(negedge Clk);
        repeat (10) @(negedge Clk);
        chk("abort_w0", 32'(wl(mark)),     {21'd0, 3'd1, 8'h55});
        chk("abort_w1", 32'(wl(mark + 1)), {21'd0, 3'd1, 8'h66});
        chk("abort_w2", 32'(wl(mark + 2)), {21'd0, 3'd0, 8'h02});
        chk("abort_w3", 32'(wl(mark + 3)), {21'd0, 3'd0, 8'h04});
        chk("abort_pulses", 32'(txab_cnt - base_ab), 32'd1);
        chk("abort_no_done", 32'(txdone_cnt - base_done), 32'd0);

        // 130 bytes without TxLast: buffer limit forces the enable after 126
        mark = wlog.size(); base_done = txdone_cnt;
        tx_done_at = tx_polls + 2;
        pre_done = 0; acc_fail = 0;
        for (int i = 0; i < 130; i++) begin
            send_byte(8'(i), 1'b0, ok);
            if (!ok) acc_fail++;
            if (txdone_cnt == base_done) pre_done++;
        end
        chk("max_all_accepted", 32'(acc_fail), 32'd0);
        chk("max_before_done", 32'(pre_done), 32'd126);
        chk("max_126th_write", 32'(wl(mark + 125)), {21'd0, 3'd1, 8'd125});
        chk("max_enable_write", 32'(wl(mark + 126)), {21'd0, 3'd0, 8'h02});
        chk("max_127th_write", 32'(wl(mark + 127)), {21'd0, 3'd1, 8'd126});
        send_byte(8'hEE, 1'b1, ok);
        for (int i = 0; i < 200 && txdone_cnt < base_done + 2; i++) @(negedge Clk);
        chk("max_second_done", 32'(txdone_cnt - base_done), 32'd2);

        // FCS disabled instance and global bus rules
        chk("fcs0_init_write", 32'(w0l(0)), {21'd0, 3'd2, 8'h00});
        chk("fcs0_drop_write", 32'(w0l(1)), {21'd0, 3'd2, 8'h02});
        chk("fcs0_err_code", 32'(d0_err_last), 32'd2);
        chk("bus_rules", 32'(bus_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
